cve2_irq_ctrl: RTL and testbench

- Interrupt source for the core: the transmitting end of the core's `irqs_t` interrupt-request interface.
- Collects up to 16 external fast-interrupt lines, an external-interrupt line, a software-interrupt register and a machine timer (mtime/mtimecmp).
- Drives the core's `irq_software`, `irq_timer`, `irq_external` and `irq_fast[15:0]` inputs.
- Configured and acknowledged through a small single-cycle register port from the system bus.

---
 rtl/cve2_irq_ctrl_pkg.sv | 22 ++
 rtl/cve2_irq_gateway.sv | 44 ++++
 rtl/cve2_irq_ctrl.sv | 134 +++++++++++++
 tb/tb_cve2_irq_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cve2_irq_ctrl_pkg.sv
// rtl/cve2_irq_ctrl_pkg.sv - shared types and register offsets for the interrupt controller
package cve2_irq_ctrl_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [15:0] irq_fast;
    } irqs_t;

    localparam int unsigned IRQC_NUM_FAST_MAX = 16;

    localparam logic [3:0] IRQC_OFF_PENDING     = 4'h0;
    localparam logic [3:0] IRQC_OFF_ENABLE      = 4'h1;
    localparam logic [3:0] IRQC_OFF_MODE        = 4'h2;
    localparam logic [3:0] IRQC_OFF_MSIP        = 4'h3;
    localparam logic [3:0] IRQC_OFF_MTIME_LO    = 4'h4;
    localparam logic [3:0] IRQC_OFF_MTIME_HI    = 4'h5;
    localparam logic [3:0] IRQC_OFF_MTIMECMP_LO = 4'h6;
    localparam logic [3:0] IRQC_OFF_MTIMECMP_HI = 4'h7;

endpackage

// File: rtl/cve2_irq_gateway.sv
// rtl/cve2_irq_gateway.sv - per-source synchronizer, edge detect and level/edge pending latch
module cve2_irq_gateway (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic mode_i,
    input  logic w1c_i,
    output logic pending_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic pending_q, pending_d;

    always_comb begin
        sync1_d = src_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        // A fresh edge overrides a same-cycle clear so no event is ever lost.
        if (mode_i) begin
            pending_d = (pending_q & ~w1c_i) | (sync2_q & ~prev_q);
        end else begin
            pending_d = sync2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/cve2_irq_ctrl.sv
// rtl/cve2_irq_ctrl.sv - interrupt source for the core: fast lines, external, software and machine timer
module cve2_irq_ctrl
    import cve2_irq_ctrl_pkg::*;
#(
    parameter int unsigned NumFastSrc = 16,
    parameter int unsigned MtimeWidth = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumFastSrc-1:0] irq_src_i,
    input  logic                  irq_ext_i,
    input  logic                  tick_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [3:0]            addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output irqs_t                 irqs_o
);

    localparam int unsigned HiW = MtimeWidth - 32;

    logic [NumFastSrc-1:0] enable_q, enable_d;
    logic [NumFastSrc-1:0] mode_q, mode_d;
    logic                  msip_q, msip_d;
    logic [MtimeWidth-1:0] mtime_q, mtime_d;
    logic [MtimeWidth-1:0] mtimecmp_q, mtimecmp_d;
    logic                  irq_timer_q, irq_timer_d;
    logic                  ext_sync1_q, ext_sync1_d;
    logic                  ext_sync2_q, ext_sync2_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [NumFastSrc-1:0] pending;
    logic [NumFastSrc-1:0] w1c;
    logic                  wr_en;
    logic [31:0]           rd_val;

    for (genvar i = 0; i < NumFastSrc; i++) begin : g_gw
        cve2_irq_gateway u_gw (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .src_i    (irq_src_i[i]),
            .mode_i   (mode_q[i]),
            .w1c_i    (w1c[i]),
            .pending_o(pending[i])
        );
    end

    always_comb begin
        wr_en = req_i & we_i & ~addr_i[3];
        w1c   = (wr_en && addr_i == IRQC_OFF_PENDING) ? wdata_i[NumFastSrc-1:0] : '0;

        rd_val = '0;
        case (addr_i)
            IRQC_OFF_PENDING:     rd_val = 32'(pending);
            IRQC_OFF_ENABLE:      rd_val = 32'(enable_q);
            IRQC_OFF_MODE:        rd_val = 32'(mode_q);
            IRQC_OFF_MSIP:        rd_val = 32'(msip_q);
            IRQC_OFF_MTIME_LO:    rd_val = mtime_q[31:0];
            IRQC_OFF_MTIME_HI:    rd_val = 32'(mtime_q[MtimeWidth-1:32]);
            IRQC_OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
            IRQC_OFF_MTIMECMP_HI: rd_val = 32'(mtimecmp_q[MtimeWidth-1:32]);
            default:              rd_val = '0;
        endcase

        rvalid_d = req_i;
        err_d    = req_i & addr_i[3];
        rdata_d  = (req_i && !we_i && !addr_i[3]) ? rd_val : '0;

        enable_d   = enable_q;
        mode_d     = mode_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en && addr_i == IRQC_OFF_ENABLE)      enable_d = wdata_i[NumFastSrc-1:0];
        if (wr_en && addr_i == IRQC_OFF_MODE)        mode_d   = wdata_i[NumFastSrc-1:0];
        if (wr_en && addr_i == IRQC_OFF_MSIP)        msip_d   = wdata_i[0];
        if (wr_en && addr_i == IRQC_OFF_MTIMECMP_LO) mtimecmp_d = {mtimecmp_q[MtimeWidth-1:32], wdata_i};
        if (wr_en && addr_i == IRQC_OFF_MTIMECMP_HI) mtimecmp_d = {wdata_i[HiW-1:0], mtimecmp_q[31:0]};

        // A software write replaces the tick increment for that cycle.
        mtime_d = tick_i ? mtime_q + MtimeWidth'(1) : mtime_q;
        if (wr_en && addr_i == IRQC_OFF_MTIME_LO) mtime_d = {mtime_q[MtimeWidth-1:32], wdata_i};
        if (wr_en && addr_i == IRQC_OFF_MTIME_HI) mtime_d = {wdata_i[HiW-1:0], mtime_q[31:0]};

        irq_timer_d = (mtime_q >= mtimecmp_q);
        ext_sync1_d = irq_ext_i;
        ext_sync2_d = ext_sync1_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q    <= '0;
            mode_q      <= '0;
            msip_q      <= 1'b0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            irq_timer_q <= 1'b0;
            ext_sync1_q <= 1'b0;
            ext_sync2_q <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            msip_q      <= msip_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            irq_timer_q <= irq_timer_d;
            ext_sync1_q <= ext_sync1_d;
            ext_sync2_q <= ext_sync2_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        irqs_o                             = '0;
        irqs_o.irq_software                = msip_q;
        irqs_o.irq_timer                   = irq_timer_q;
        irqs_o.irq_external                = ext_sync2_q;
        irqs_o.irq_fast[NumFastSrc-1:0]    = pending & enable_q;
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_cve2_irq_ctrl.sv
// tb/tb_cve2_irq_ctrl.sv - scoreboard bench for cve2_irq_ctrl, two parameterisations driven in lockstep
module tb_cve2_irq_ctrl;
    import cve2_irq_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, irq_ext_i, tick_i, req_i, we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [15:0] src;

    logic        rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    irqs_t       irqs0, irqs1;

    cve2_irq_ctrl #(.NumFastSrc(16), .MtimeWidth(64)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .irq_src_i(src), .irq_ext_i(irq_ext_i),
        .tick_i(tick_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0), .irqs_o(irqs0)
    );

    cve2_irq_ctrl #(.NumFastSrc(4), .MtimeWidth(40)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .irq_src_i(src[3:0]), .irq_ext_i(irq_ext_i),
        .tick_i(tick_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1), .irqs_o(irqs1)
    );

    typedef struct packed {
        logic             valid;
        logic [1:0]       err;
        logic [1:0][31:0] rdata;
        logic [1:0][18:0] irqs;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference state, one slot per parameterisation.
    logic [31:0] m_pend[2], m_en[2], m_mode[2];
    logic        m_msip[2], m_tim[2];
    logic [63:0] m_mtime[2], m_cmp[2];
    logic [15:0] s1, s2, s3;
    logic        e1;

    function automatic logic [31:0] fmask(int d);
        return (d == 0) ? 32'h0000_FFFF : 32'h0000_000F;
    endfunction

    function automatic logic [63:0] tmask(int d);
        return (d == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_00FF_FFFF_FFFF;
    endfunction

    task automatic model_step();
        exp_t e;
        e = '0;
        if (rst_i) begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = '0; m_en[d] = '0; m_mode[d] = '0;
                m_msip[d] = 1'b0; m_tim[d] = 1'b0;
                m_mtime[d] = '0; m_cmp[d] = tmask(d);
            end
            s1 = '0; s2 = '0; s3 = '0; e1 = 1'b0;
        end else begin
            e.valid = req_i;
            for (int d = 0; d < 2; d++) begin
                logic [31:0] rd, w1c, lvl, edg;
                logic        wr, bad;
                logic [63:0] nt, nc;
                bad = (addr_i >= 4'd8);
                case (addr_i)
                    4'd0:    rd = m_pend[d];
                    4'd1:    rd = m_en[d];
                    4'd2:    rd = m_mode[d];
                    4'd3:    rd = {31'b0, m_msip[d]};
                    4'd4:    rd = m_mtime[d][31:0];
                    4'd5:    rd = m_mtime[d][63:32];
                    4'd6:    rd = m_cmp[d][31:0];
                    4'd7:    rd = m_cmp[d][63:32];
                    default: rd = '0;
                endcase
                e.err[d]   = req_i && bad;
                e.rdata[d] = (req_i && !we_i && !bad) ? rd : 32'h0;
                wr  = req_i && we_i && !bad;
                w1c = (wr && addr_i == 4'd0) ? wdata_i : 32'h0;
                // Sources reach the pending logic two samples late; an edge is a 0->1 step of that delayed view.
                lvl = {16'b0, s2} & fmask(d);
                edg = {16'b0, s2 & ~s3} & fmask(d);
                m_tim[d]  = (m_mtime[d] >= m_cmp[d]);
                m_pend[d] = ((m_mode[d] & ((m_pend[d] & ~w1c) | edg)) | (~m_mode[d] & lvl)) & fmask(d);
                nt = m_mtime[d];
                if (tick_i) nt = (nt + 64'd1) & tmask(d);
                if (wr && addr_i == 4'd4) nt = {m_mtime[d][63:32], wdata_i};
                if (wr && addr_i == 4'd5) nt = ({wdata_i, 32'b0} | {32'b0, m_mtime[d][31:0]}) & tmask(d);
                m_mtime[d] = nt;
                nc = m_cmp[d];
                if (wr && addr_i == 4'd6) nc = {m_cmp[d][63:32], wdata_i};
                if (wr && addr_i == 4'd7) nc = ({wdata_i, 32'b0} | {32'b0, m_cmp[d][31:0]}) & tmask(d);
                m_cmp[d] = nc;
                if (wr && addr_i == 4'd1) m_en[d]   = wdata_i & fmask(d);
                if (wr && addr_i == 4'd2) m_mode[d] = wdata_i & fmask(d);
                if (wr && addr_i == 4'd3) m_msip[d] = wdata_i[0];
                e.irqs[d] = {m_msip[d], m_tim[d], e1, m_pend[d][15:0] & m_en[d][15:0]};
            end
            s3 = s2; s2 = s1; s1 = src; e1 = irq_ext_i;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, req);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rvalid0", 64'(rvalid0), 64'(e.valid));
                chk("rvalid1", 64'(rvalid1), 64'(e.valid));
                chk("irqs0", 64'(irqs0), 64'(e.irqs[0]));
                chk("irqs1", 64'(irqs1), 64'(e.irqs[1]));
                if (e.valid) begin
                    chk("rdata0", 64'(rdata0), 64'(e.rdata[0]));
                    chk("rdata1", 64'(rdata1), 64'(e.rdata[1]));
                    chk("err0", 64'(err0), 64'(e.err[0]));
                    chk("err1", 64'(err1), 64'(e.err[1]));
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic rq, input logic w, input logic [3:0] a, input logic [31:0] wd);
        rst_i = r; req_i = rq; we_i = w; addr_i = a; wdata_i = wd;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        cyc(1'b0, 1'b1, 1'b1, a, wd);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] wd;
        logic [3:0]  a;
        src = '0; irq_ext_i = 1'b0; tick_i = 1'b0;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        rd(4'h6);
        cyc(1'b1, 1'b1, 1'b0, 4'h6, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 4'h6, 32'h0);
        rd(4'h6); rd(4'h7);

        wr(4'h2, 32'h1); wr(4'h1, 32'h1);
        src[0] = 1'b1; idle(1); src[0] = 1'b0; idle(4);
        wr(4'h0, 32'h1); idle(2);
        src[0] = 1'b1; idle(1); src[0] = 1'b0; idle(1);
        wr(4'h0, 32'h1); idle(3); rd(4'h0);
        wr(4'h0, 32'h1); idle(2);

        wr(4'h2, 32'h0); wr(4'h1, 32'hFFFF_FFFF); rd(4'h1);
        src[5] = 1'b1; idle(4); wr(4'h0, 32'h20); idle(5);
        src[5] = 1'b0; idle(4); wr(4'h1, 32'h0);

        wr(4'h7, 32'h0); wr(4'h6, 32'h5);
        tick_i = 1'b1; idle(8);
        wr(4'h4, 32'h0); rd(4'h4); idle(3);
        tick_i = 1'b0;
        wr(4'h5, 32'hFFFF_FFFF); wr(4'h4, 32'hFFFF_FFFF);
        tick_i = 1'b1; idle(1); tick_i = 1'b0;
        rd(4'h4); rd(4'h5);
        wr(4'h7, 32'hFFFF_FFFF); wr(4'h6, 32'hFFFF_FFFF);

        rd(4'h9); wr(4'hA, 32'h1); wr(4'h3, 32'h1); rd(4'h3); wr(4'h3, 32'h0);
        irq_ext_i = 1'b1; idle(3); irq_ext_i = 1'b0; idle(3);

        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 16; i++) if ($urandom_range(7) == 0) src[i] = ~src[i];
            if ($urandom_range(15) == 0) irq_ext_i = ~irq_ext_i;
            tick_i = 1'($urandom_range(1));
            a  = 4'($urandom_range(9));
            wd = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : 32'($urandom());
            cyc(($urandom_range(499) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)), a, wd);
        end
        idle(2);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
